// File: rtl/piso_tx_scheduler.sv
// piso_tx_scheduler: round-robin arbiter in front of a single PISO shift path.
// The winner's word is captured at arbitration and shifted out MSB-first with
// a valid qualifier, a done pulse on the last bit and optional idle gap cycles.
module piso_tx_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int GAP   = 1,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] pdata,
    output logic [NREQ-1:0]       grant,
    output logic [IDW-1:0]        src_id,
    output logic                  sout,
    output logic                  sout_valid,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned NR = NREQ;
    localparam int          CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t            state;
    logic [IDW-1:0]    ptr;
    logic [WIDTH-1:0]  shift_reg;
    logic [CW-1:0]     bitcnt;
    logic [3:0]        gapcnt;
    logic [IDW-1:0]    win;
    logic [IDW-1:0]    win_next;
    logic              found;
    int unsigned       idx_w;

    // Serial line is the register MSB; the register drains to zero by the end
    // of every frame and on reset, so the line idles low without extra gating.
    assign sout = shift_reg[WIDTH-1];

    // Round-robin pick: first pending request at or after ptr, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx_w = 0;
        for (int unsigned i = 0; i < NR; i++) begin
            idx_w = 32'(ptr) + i;
            if (idx_w >= NR) begin
                idx_w = idx_w - NR;
            end
            if (!found && req[IDW'(idx_w)]) begin
                found = 1'b1;
                win   = IDW'(idx_w);
            end
        end
        if (32'(win) == NR - 1) begin
            win_next = '0;
        end else begin
            win_next = win + IDW'(1);
        end
    end

    // Scheduler FSM: arbitration/load, MSB-first shifting, inter-frame gap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            shift_reg  <= '0;
            bitcnt     <= '0;
            gapcnt     <= '0;
            grant      <= '0;
            src_id     <= '0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            grant <= '0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        shift_reg  <= pdata[32'(win)*WIDTH +: WIDTH];
                        grant      <= NREQ'(1) << win;
                        src_id     <= win;
                        ptr        <= win_next;
                        bitcnt     <= CW'(WIDTH - 1);
                        sout_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    if (bitcnt == '0) begin
                        sout_valid <= 1'b0;
                        if (GAP > 0) begin
                            gapcnt <= 4'(GAP - 1);
                            state  <= S_GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else begin
                        bitcnt <= bitcnt - CW'(1);
                        // done is registered, so it is raised one edge early
                        done   <= (bitcnt == CW'(1));
                    end
                end
                S_GAP: begin
                    if (gapcnt == '0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gapcnt <= gapcnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Self-checking bench for piso_tx_scheduler: a frame-timeline model checks the
// default instance every cycle; a WIDTH=8/GAP=0 instance is checked by hand.
module tb_piso_tx_scheduler;

    localparam int W = 4;
    localparam int G = 1;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] pdata;
    logic [3:0]  grant;
    logic [1:0]  src_id;
    logic        sout, sout_valid, done, busy;

    logic [3:0]  req1;
    logic [31:0] pdata1;
    logic [3:0]  grant1;
    logic [1:0]  src_id1;
    logic        sout1, sout_valid1, done1, busy1;

    int ntest = 0;
    int nfail = 0;

    piso_tx_scheduler u0 (
        .clock(clock), .reset(reset), .req(req), .pdata(pdata),
        .grant(grant), .src_id(src_id), .sout(sout),
        .sout_valid(sout_valid), .done(done), .busy(busy)
    );

    piso_tx_scheduler #(.WIDTH(8), .GAP(0)) u1 (
        .clock(clock), .reset(reset), .req(req1), .pdata(pdata1),
        .grant(grant1), .src_id(src_id1), .sout(sout1),
        .sout_valid(sout_valid1), .done(done1), .busy(busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Model: each arbitration lays out the whole frame as a list of per-cycle
    // expected outputs (WIDTH bits, GAP idle-busy cycles, one idle cycle).
    typedef struct packed {
        logic [3:0] g;
        logic       s;
        logic       v;
        logic       d;
        logic       b;
    } exp_t;

    exp_t       tl[$];
    exp_t       cur;
    logic [1:0] exp_src;
    int         mptr;
    int         mw;
    logic [3:0] mword;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            tl.delete();
            cur     = '0;
            exp_src = '0;
            mptr    = 0;
        end else begin
            if (tl.size() == 0 && req != 4'b0) begin
                mw = -1;
                for (int k = 0; k < 4; k++)
                    if (mw < 0 && req[(mptr + k) % 4]) mw = (mptr + k) % 4;
                mword   = pdata[mw*W +: W];
                mptr    = (mw + 1) % 4;
                exp_src = 2'(mw);
                for (int k = 0; k < W; k++)
                    tl.push_back('{g: (k == 0) ? 4'(1 << mw) : 4'b0,
                                   s: mword[W-1-k], v: 1'b1,
                                   d: (k == W - 1), b: 1'b1});
                for (int k = 0; k < G; k++)
                    tl.push_back('{g: 4'b0, s: 1'b0, v: 1'b0, d: 1'b0, b: 1'b1});
                tl.push_back('{g: 4'b0, s: 1'b0, v: 1'b0, d: 1'b0, b: 1'b0});
            end
            if (tl.size() != 0) cur = tl.pop_front();
            else                cur = '0;
        end
    end

    // Compare the default instance with the model on every falling edge.
    always @(negedge clock) begin
        ntest++;
        if ({grant, sout, sout_valid, done, busy, src_id} !== {cur, exp_src}) begin
            nfail++;
            $display("FAIL model_cycle t=%0t got g=%b s=%b v=%b d=%b b=%b id=%0d, expected g=%b s=%b v=%b d=%b b=%b id=%0d",
                     $time, grant, sout, sout_valid, done, busy, src_id,
                     cur.g, cur.s, cur.v, cur.d, cur.b, exp_src);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic nxt;
        @(negedge clock);
        #1;
    endtask

    logic [7:0] t1_exp [6];
    int         gidx [8];
    int         gcyc [8];
    int         n;
    int         gi;
    int         exp_order [8];
    logic [7:0] pat;
    logic [7:0] e;
    int         p;

    initial begin
        t1_exp    = '{8'h1D, 8'h05, 8'h0D, 8'h07, 8'h01, 8'h00};
        exp_order = '{0, 1, 2, 3, 0, 1, 3, 0};
        reset  = 1'b1;
        req    = '0;
        pdata  = '0;
        req1   = '0;
        pdata1 = '0;
        repeat (3) nxt;
        check("rst_outputs", {grant, src_id, sout, sout_valid, done, busy}, 32'h0);
        check("rst_outputs_w8", {grant1, src_id1, sout1, sout_valid1, done1, busy1}, 32'h0);
        reset = 1'b0;
        nxt;

        // Single request from requester 0, word 1010
        pdata = 16'h000A;
        req   = 4'b0001;
        nxt;
        req = 4'b0000;
        check("single_src", src_id, 0);
        for (int c = 0; c < 6; c++) begin
            check($sformatf("single_c%0d", c), {grant, sout, sout_valid, done, busy}, t1_exp[c]);
            nxt;
        end

        reset = 1'b1;
        nxt;
        nxt;
        reset = 1'b0;
        nxt;

        // All requesters active, then only 3 and 0 after the grant to 1
        pdata = 16'h5C3A;
        n     = 0;
        req   = 4'b1111;
        for (int t = 0; t < 120 && n < 8; t++) begin
            nxt;
            if (grant != 4'b0) begin
                gi = -1;
                for (int k = 0; k < 4; k++) if (grant[k]) gi = k;
                gidx[n] = gi;
                gcyc[n] = t;
                n++;
            end
            req = ((n < 6) ? 4'b1111 : 4'b1001) & ~grant;
        end
        req = 4'b0000;
        check("rr_grant_count", n, 8);
        for (int k = 0; k < n; k++)
            check($sformatf("rr_order%0d", k), gidx[k], exp_order[k]);
        for (int k = 1; k < n; k++)
            check($sformatf("rr_period%0d", k), gcyc[k] - gcyc[k-1], 6);
        repeat (8) nxt;

        // Reset during the second SHIFT cycle of a frame to requester 1
        req = 4'b0010;
        nxt;
        req = 4'b0000;
        check("mid_grant", grant, 4'b0010);
        @(posedge clock);
        #2;
        check("mid_busy_before", busy, 1);
        check("mid_valid_before", sout_valid, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_outputs", {grant, src_id, sout, sout_valid, done, busy}, 32'h0);
        nxt;
        reset = 1'b0;
        req   = 4'b0110;
        nxt;
        req = 4'b0000;
        check("post_rst_grant", grant, 4'b0010);
        check("post_rst_src", src_id, 1);
        repeat (8) nxt;

        // WIDTH=8/GAP=0 instance streams A5 from requester 2; default stays idle
        pat    = 8'hA5;
        pdata1 = 32'h3CA55AC3;
        req1   = 4'b0100;
        for (int c = 0; c < 27; c++) begin
            nxt;
            pdata = ~pdata;
            p = c % 9;
            if (p < 8) e = {(p == 0) ? 4'b0100 : 4'b0000, pat[7-p], 1'b1, (p == 7), 1'b1};
            else       e = 8'h00;
            check($sformatf("w8_c%0d", c), {grant1, sout1, sout_valid1, done1, busy1}, e);
            if (c == 0) check("w8_src", src_id1, 2);
        end
        req1 = 4'b0000;
        repeat (10) nxt;
        check("idle_end", {grant, sout, sout_valid, done, busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule

// File: doc/piso_tx_scheduler.md
# piso_tx_scheduler

Round-robin scheduler that shares one parallel-in/serial-out shift path among NREQ requesters. It arbitrates among pending requests and captures the winner's parallel word into an internal PISO shift register. It then shifts the word out MSB-first with a valid qualifier. It sits between the parallel producers and the single serial output line, and owns all load/shift sequencing.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 4: bits per word, ≥2.
- GAP, 1: idle cycles inserted after each frame, 0..15.
- IDW, $clog2(NREQ): width of src_id.

- clock  in  1  rising-edge clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request, level.
- pdata  in  NREQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH].
- grant  out  NREQ  one-hot, one-cycle acknowledge that the word was captured.
- src_id  out  IDW  index of the requester owning the current frame.
- sout  out  1  serial data, MSB first.
- sout_valid  out  1  sout carries a frame bit this cycle.
- done  out  1  one-cycle pulse coincident with the last bit of a frame.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If req ≠ 0 at a rising edge, select the winner by round robin.
  - On that same edge: load shift_reg ← winner's pdata, register grant ← onehot(winner) and src_id ← winner, set bit counter ← WIDTH-1, go to SHIFT.
- Round robin:
  - Search starts at ptr and wraps modulo NREQ.
  - After each grant, ptr ← winner+1, mod NREQ.
  - Reset value of ptr is 0, so the first arbitration has fixed priority 0 > 1 > … > NREQ-1.
- SHIFT:
  - sout = shift_reg[WIDTH-1], sout_valid = 1.
  - Each edge shifts left, filling with 0, and decrements the counter.
  - In the cycle where counter = 0, done = 1. The next edge goes to GAP if GAP > 0, else IDLE.
- GAP: sout_valid = 0 for exactly GAP cycles, then go to IDLE.
- req is sampled only at IDLE arbitration edges.
  - A requester must hold req and pdata stable until it sees its grant bit.
  - It must drop req in the grant cycle, or it will be re-queued for a later frame.
  - Changes to pdata after grant have no effect on the frame in flight.
- When not in SHIFT, sout = 0 and done = 0.
- src_id holds its value from the grant until the next grant.
- grant is high only in the first SHIFT cycle.
- Reset, at any time including mid-frame:
  - All outputs go to 0 immediately: grant, src_id, sout, sout_valid, done, busy.
  - state → IDLE, ptr → 0, shift_reg → 0.
  - The frame in flight is abandoned with no done pulse.
- Simultaneous requests: only one winner per arbitration. Losers wait with req held and are served in rotation order.

## Timing
- Latency: a request seen at an IDLE edge E produces grant, the first bit (MSB) and sout_valid in the cycle after E.
- Bit k, counting from 0 at the MSB, appears k cycles later.
- done is high in cycle E+WIDTH, together with the LSB.
- Frame period under continuous requests is 1 + WIDTH + GAP cycles: one IDLE, WIDTH SHIFT, GAP idle. With the defaults this is 6 cycles.
- IDLE always lasts at least 1 cycle between frames, including when GAP = 0.
- All outputs are registered; there are no combinational paths from req or pdata to any output.

## Test plan
- Single request, defaults:
  - Stimulus: req = 0001, pdata[3:0] = 1010, req held for one arbitration only.
  - Response: grant = 0001 for 1 cycle, src_id = 0, sout = 1,0,1,0 with sout_valid on 4 consecutive cycles, done on the 4th, then 1 GAP cycle, then busy = 0.
- All requesters continuously active: req = 1111, each requester drops req for the cycle after its grant, then re-raises it.
  - Required grant order from reset: 0,1,2,3,0,1.
  - Consecutive grants are 6 cycles apart.
- Rotation skip:
  - Stimulus: after a grant to requester 1, only req[3] and req[0] are active.
  - Response: the next grant goes to 3, then 0.
- Reset mid-frame:
  - Stimulus: assert reset asynchronously during the 2nd SHIFT cycle.
  - Response: all outputs go to 0 with no clock edge, no done pulse, and after release the next grant follows priority from requester 0.
- GAP = 0, WIDTH = 8, req[2] held continuously with pdata = 8'hA5:
  - sout = 1,0,1,0,0,1,0,1 per frame.
  - Frames repeat every 9 cycles, with exactly one IDLE cycle where sout_valid = 0.
- Idle line: with req = 0 for 20 cycles, busy, sout, sout_valid, grant and done all stay 0, and pdata toggling is ignored.
